// File: rtl/mbist_pkg.sv
// Shared types and per-element constants for the March C- BIST sequencer.
// Elements E0..E5 are indexed directly into the constant tables below.
package mbist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam int ELEM_W = 3;

    localparam logic [ELEM_W-1:0] E0 = 3'd0;
    localparam logic [ELEM_W-1:0] E1 = 3'd1;
    localparam logic [ELEM_W-1:0] E2 = 3'd2;
    localparam logic [ELEM_W-1:0] E3 = 3'd3;
    localparam logic [ELEM_W-1:0] E4 = 3'd4;
    localparam logic [ELEM_W-1:0] E5 = 3'd5;

    // One bit per element, bit index = element number.
    localparam logic [7:0] ELEM_TWO_OP = 8'b0001_1110;
    localparam logic [7:0] ELEM_DESC   = 8'b0001_1000;
    localparam logic [7:0] ELEM_RPOL   = 8'b0001_0100;
    localparam logic [7:0] ELEM_WPOL   = 8'b0000_1010;

    function automatic logic elem_is_write(input logic [ELEM_W-1:0] e,
                                           input logic op);
        return (e == E0) || op;
    endfunction

endpackage

// File: rtl/mbist_resp_checker.sv
// Read-response checker: delays expected word/address/element alongside the
// 2-cycle memory read, compares, counts mismatches and captures the first one.
module mbist_resp_checker
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  rd_vld_i,
    input  logic [DATA_WIDTH-1:0] rd_exp_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [ELEM_W-1:0]     rd_elem_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [CNT_WIDTH-1:0]  fail_count_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [ELEM_W-1:0]     fail_elem_o,
    output logic [DATA_WIDTH-1:0] fail_exp_o,
    output logic [DATA_WIDTH-1:0] fail_act_o
);

    logic                  vld1_q, vld2_q;
    logic [DATA_WIDTH-1:0] exp1_q, exp2_q;
    logic [ADDR_WIDTH-1:0] addr1_q, addr2_q;
    logic [ELEM_W-1:0]     elem1_q, elem2_q;

    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
    logic [ELEM_W-1:0]     felem_q, felem_d;
    logic [DATA_WIDTH-1:0] fexp_q, fexp_d;
    logic [DATA_WIDTH-1:0] fact_q, fact_d;
    logic                  mismatch;

    // The counter saturates, so a zero count always means no mismatch yet.
    always_comb begin
        mismatch = vld2_q && (rdata_i != exp2_q);
        cnt_d    = cnt_q;
        faddr_d  = faddr_q;
        felem_d  = felem_q;
        fexp_d   = fexp_q;
        fact_d   = fact_q;
        if (mismatch) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_q == '0) begin
                faddr_d = addr2_q;
                felem_d = elem2_q;
                fexp_d  = exp2_q;
                fact_d  = rdata_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            exp1_q  <= '0;
            exp2_q  <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
            elem1_q <= '0;
            elem2_q <= '0;
            cnt_q   <= '0;
            faddr_q <= '0;
            felem_q <= '0;
            fexp_q  <= '0;
            fact_q  <= '0;
        end else if (clr_i) begin
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            exp1_q  <= '0;
            exp2_q  <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
            elem1_q <= '0;
            elem2_q <= '0;
            cnt_q   <= '0;
            faddr_q <= '0;
            felem_q <= '0;
            fexp_q  <= '0;
            fact_q  <= '0;
        end else begin
            vld1_q  <= rd_vld_i;
            vld2_q  <= vld1_q;
            exp1_q  <= rd_exp_i;
            exp2_q  <= exp1_q;
            addr1_q <= rd_addr_i;
            addr2_q <= addr1_q;
            elem1_q <= rd_elem_i;
            elem2_q <= elem1_q;
            cnt_q   <= cnt_d;
            faddr_q <= faddr_d;
            felem_q <= felem_d;
            fexp_q  <= fexp_d;
            fact_q  <= fact_d;
        end
    end

    assign fail_count_o = cnt_q;
    assign fail_addr_o  = faddr_q;
    assign fail_elem_o  = felem_q;
    assign fail_exp_o   = fexp_q;
    assign fail_act_o   = fact_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer: FSM, element/op/address counters and memory drive.
// Read checking and failure capture live in mbist_resp_checker.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 15,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_act,
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(CAPACITY);

    state_e              state_q, state_d;
    logic [ELEM_W-1:0]   elem_q, elem_d, elem_nx;
    logic                op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]          drain_q, drain_d;
    logic                pass_q, pass_d;
    logic                accept, run, desc, last_op, is_write, addr_end;

    always_comb begin
        accept   = start && (state_q == S_IDLE || state_q == S_DONE);
        run      = (state_q == S_RUN);
        desc     = ELEM_DESC[elem_q];
        last_op  = !ELEM_TWO_OP[elem_q] || op_q;
        is_write = elem_is_write(elem_q, op_q);
        addr_end = desc ? (addr_q == '0) : (addr_q == ADDR_MAX);
        elem_nx  = elem_q + 1'b1;

        state_d = state_q;
        elem_d  = elem_q;
        op_d    = op_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        pass_d  = pass_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d = S_PRIME;
                    pass_d  = 1'b0;
                end
            end
            S_PRIME: begin
                state_d = S_RUN;
                elem_d  = E0;
                op_d    = 1'b0;
                addr_d  = '0;
            end
            S_RUN: begin
                if (!last_op) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (addr_end) begin
                        elem_d = elem_nx;
                        addr_d = ELEM_DESC[elem_nx] ? ADDR_MAX : '0;
                        if (elem_q == E5) begin
                            state_d = S_DRAIN;
                            drain_d = '0;
                        end
                    end else begin
                        addr_d = desc ? addr_q - 1'b1 : addr_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == 2'd2) begin
                    state_d = S_DONE;
                    pass_d  = (fail_count == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            elem_q  <= '0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            drain_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            pass_q  <= pass_d;
        end
    end

    assign busy = (state_q == S_PRIME) || run || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);
    assign pass = pass_q;

    // Write data is the polarity of whatever element issues next cycle's op.
    assign mem_write_read = run && is_write;
    assign mem_address    = run ? addr_q : '0;
    assign mem_wdata      = (state_q == S_PRIME || run) ?
                            {DATA_WIDTH{ELEM_WPOL[elem_d]}} : '0;

    mbist_resp_checker #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_chk (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (accept),
        .rd_vld_i     (run && !is_write),
        .rd_exp_i     ({DATA_WIDTH{ELEM_RPOL[elem_q]}}),
        .rd_addr_i    (addr_q),
        .rd_elem_i    (elem_q),
        .rdata_i      (mem_rdata),
        .fail_count_o (fail_count),
        .fail_addr_o  (fail_addr),
        .fail_elem_o  (fail_elem),
        .fail_exp_o   (fail_exp),
        .fail_act_o   (fail_act)
    );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: faulty-memory model, March C- reference model,
// bus-op and result scoreboards.
module tb_mbist_march_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int CAP = 15;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, pass;
    logic [CW-1:0] fail_count;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [DW-1:0] fail_exp, fail_act;
    logic          mem_write_read;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mbist_march_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CAPACITY   (CAP),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_count     (fail_count),
        .fail_addr      (fail_addr),
        .fail_elem      (fail_elem),
        .fail_exp       (fail_exp),
        .fail_act       (fail_act),
        .mem_write_read (mem_write_read),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    // kind: 0 none, 1 stuck bit b of addr a at v, 2 write to agg copies to vic
    typedef struct {int kind; int a; int b; int v; int agg; int vic;} fault_t;
    typedef struct {bit ok; int cnt; int addr; int elem; int expw; int act;} res_t;
    typedef struct {bit we; int addr; int data;} op_t;

    fault_t flt = '{0, 0, 0, 0, 0, 1};
    res_t   exp_q[$];
    op_t    ops_q[$];
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic logic [7:0] fault_rd(input int a, input logic [7:0] d);
        logic [7:0] r = d;
        if (flt.kind == 1 && a == flt.a) r[flt.b] = flt.v[0];
        return r;
    endfunction

    // Cycle-level memory: write data registered one cycle early, 2-cycle reads.
    logic [7:0] tmem [16];
    logic [7:0] wq;
    logic [3:0] raddr;
    always @(posedge clk) begin
        if (mem_write_read) begin
            tmem[mem_address] <= wq;
            if (flt.kind == 2 && int'(mem_address) == flt.agg) tmem[flt.vic] <= wq;
        end
        wq        <= mem_wdata;
        raddr     <= mem_address;
        mem_rdata <= fault_rd(int'(raddr), tmem[raddr]);
    end

    // Untimed March C- on the same faulty memory.
    logic [7:0] rm [16];
    res_t rr;
    int   cur_e;

    task automatic ref_rd(input int a, input logic [7:0] e);
        logic [7:0] d;
        ops_q.push_back('{1'b0, a, 0});
        d = fault_rd(a, rm[a]);
        if (d !== e) begin
            if (rr.cnt == 0) rr = '{1'b0, 0, a, cur_e, int'(e), int'(d)};
            rr.cnt++;
        end
    endtask

    task automatic ref_wr(input int a, input logic [7:0] d);
        ops_q.push_back('{1'b1, a, int'(d)});
        rm[a] = d;
        if (flt.kind == 2 && a == flt.agg) rm[flt.vic] = d;
    endtask

    task automatic ref_march();
        int a;
        rr = '{1'b1, 0, 0, 0, 0, 0};
        foreach (rm[i]) rm[i] = 8'h00;
        for (int e = 0; e < 6; e++) begin
            cur_e = e;
            for (int i = 0; i <= CAP; i++) begin
                a = (e == 3 || e == 4) ? CAP - i : i;
                case (e)
                    0: ref_wr(a, 8'h00);
                    1: begin ref_rd(a, 8'h00); ref_wr(a, 8'hFF); end
                    2: begin ref_rd(a, 8'hFF); ref_wr(a, 8'h00); end
                    3: begin ref_rd(a, 8'h00); ref_wr(a, 8'hFF); end
                    4: begin ref_rd(a, 8'hFF); ref_wr(a, 8'h00); end
                    default: ref_rd(a, 8'h00);
                endcase
            end
        end
        rr.ok = (rr.cnt == 0);
        exp_q.push_back(rr);
    endtask

    // Monitor: busy-cycle 1 is PRIME, 2..161 are RUN ops, then DRAIN.
    int         bcnt = 0;
    bit         done_p = 1'b0;
    logic [7:0] wd_p = 8'h00;
    op_t        o;
    res_t       r;
    always @(negedge clk) begin
        if (rst) begin
            bcnt   = 0;
            done_p = 1'b0;
        end else begin
            if (busy) begin
                bcnt++;
                if (bcnt >= 2 && bcnt <= 161) begin
                    if (ops_q.size() == 0) begin
                        chk("op_underflow", 1, 0);
                    end else begin
                        o = ops_q.pop_front();
                        chk($sformatf("bus_op%0d", bcnt),
                            {mem_write_read, mem_address, mem_write_read ? wd_p : 8'h00},
                            {o.we, 4'(o.addr), o.we ? 8'(o.data) : 8'h00});
                    end
                end else begin
                    chk("idle_bus", {mem_write_read, mem_address}, 0);
                end
            end
            if (done && !done_p) begin
                chk("busy_len", bcnt, 164);
                chk("ops_left", ops_q.size(), 0);
                bcnt = 0;
                if (exp_q.size() == 0) begin
                    chk("res_underflow", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    chk("pass", pass, r.ok);
                    chk("fail_count", fail_count, r.cnt);
                    chk("fail_addr", fail_addr, r.addr);
                    chk("fail_elem", fail_elem, r.elem);
                    chk("fail_exp", fail_exp, r.expw);
                    chk("fail_act", fail_act, r.act);
                end
            end
            done_p = done;
        end
        wd_p = mem_wdata;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic run(input fault_t f, input bit repulse);
        flt = f;
        ref_march();
        pulse_start();
        if (repulse) begin
            repeat (48) @(negedge clk);
            pulse_start();
        end
        wait_done();
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {busy, done, pass, fail_count, fail_addr, fail_elem, fail_exp,
                 fail_act, mem_write_read, mem_address, mem_wdata}, 0);
    endtask

    fault_t rf;

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset_outs");
        rst = 1'b0;
        @(negedge clk);

        run('{0, 0, 0, 0, 0, 1}, 1'b0);
        chk("clean_done", done, 1);
        chk("clean_pass", pass, 1);
        chk("clean_cnt", fail_count, 0);

        run('{2, 0, 0, 0, 4, 5}, 1'b0);
        chk("cpl_pass", pass, 0);
        chk("cpl_cnt_nz", fail_count != 0, 1);
        chk("cpl_addr", fail_addr, 5);

        run('{1, 3, 0, 1, 0, 1}, 1'b0);
        chk("sa1_elem", fail_elem, 1);
        chk("sa1_addr", fail_addr, 3);
        chk("sa1_exp", fail_exp, 8'h00);
        chk("sa1_act", fail_act, 8'h01);
        chk("sa1_cnt", fail_count, 3);

        run('{0, 0, 0, 0, 0, 1}, 1'b1);
        chk("repulse_pass", pass, 1);

        flt = '{1, 3, 0, 1, 0, 1};
        ref_march();
        pulse_start();
        repeat (79) @(negedge clk);
        chk("pre_rst_cnt", fail_count != 0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrun_rst_outs");
        exp_q.delete();
        ops_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run('{0, 0, 0, 0, 0, 1}, 1'b0);
        chk("post_rst_pass", pass, 1);

        for (int i = 0; i < 8; i++) begin
            rf.kind = $urandom_range(0, 2);
            rf.a    = $urandom_range(0, CAP);
            rf.b    = $urandom_range(0, DW - 1);
            rf.v    = $urandom_range(0, 1);
            rf.agg  = $urandom_range(0, CAP);
            rf.vic  = (rf.agg + $urandom_range(1, CAP)) % (CAP + 1);
            run(rf, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

March C- sequencer for the memory-BIST flow: on `start` it drives the memory under test (the `fault_mem` port set: `write_read`, `address`, `wdata`, `rdata`) through the six March C- elements. It compares every read against the expected background and reports pass/fail plus first-failure diagnostics. It sits between the chip-level BIST enable and one memory instance, and is the only master of that memory while busy.

## Interface
- `DATA_WIDTH`, 8: memory word width.
- `ADDR_WIDTH`, 4: memory address width.
- `CAPACITY`, 15: highest memory index; the test covers addresses 0..CAPACITY inclusive.
- `CNT_WIDTH`, 16: fail-counter width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin test; sampled only in IDLE or DONE.
- `busy` out 1: test in progress.
- `done` out 1: test finished; held high until the next accepted `start`.
- `pass` out 1: valid while `done`; 1 = no mismatches.
- `fail_count` out CNT_WIDTH: mismatching reads, saturating.
- `fail_addr` out ADDR_WIDTH: address of the first mismatch.
- `fail_elem` out 3: March element (0..5) of the first mismatch.
- `fail_exp` out DATA_WIDTH: expected word at the first mismatch.
- `fail_act` out DATA_WIDTH: actual word at the first mismatch.
- `mem_write_read` out 1: 1 = write, 0 = read.
- `mem_address` out ADDR_WIDTH: memory address.
- `mem_wdata` out DATA_WIDTH: write data, one cycle early (see Timing).
- `mem_rdata` in DATA_WIDTH: registered memory read data.

## Operation
- Elements, with D0 = all-0 and D1 = all-1:
  - E0: ⇕(w0), ascending.
  - E1: ⇑(r0,w1).
  - E2: ⇑(r1,w0).
  - E3: ⇓(r0,w1).
  - E4: ⇓(r1,w0).
  - E5: ⇕(r0), ascending.
- States:
  - IDLE → PRIME on `start`.
  - PRIME (1 cycle) → RUN.
  - RUN → DRAIN after the last E5 read.
  - DRAIN (3 cycles) → DONE.
  - DONE → PRIME on `start`.
- One memory operation per cycle in RUN, with no bubbles. Op counter 0/1 inside two-op elements.
- Address counter:
  - ascending elements count 0→CAPACITY;
  - descending elements count CAPACITY→0;
  - reload at each element boundary.
- Outside RUN: `mem_write_read`=0, `mem_address`=0 (harmless read; the result is never compared).
- Accepting `start` clears `pass`, `done`, `fail_count` and all `fail_*` registers.
- Every read compares `mem_rdata` against the expected word.
  - On mismatch: increment `fail_count` (saturate at all-ones).
  - On the first mismatch only: latch `fail_addr`, `fail_elem`, `fail_exp`, `fail_act`.
- `pass` = (`fail_count`==0), registered on entry to DONE.
- `start` while busy is ignored.
- Reset values: all outputs 0; state IDLE.
- Reset mid-test: immediate return to IDLE. The memory content is undefined afterwards and is not restored.

## Timing
- Write data leads by one cycle. The memory registers `wdata` and writes it at the next edge, with the `address` of that next cycle.
  - `mem_wdata` in cycle t must equal the data of the write issued in cycle t+1.
  - PRIME exists to present D0 for the first E0 write.
- Read latency is 2.
  - A read issued in cycle t (`mem_write_read`=0, `mem_address`=A) returns on `mem_rdata` during cycle t+2.
  - Expected word, address and element travel through a 2-stage delay pipe alongside the read.
  - The compare result is registered at the end of cycle t+2.
- A read of an address written in the immediately preceding cycle returns the new data. This covers the E2→E3 and E4→E5 boundaries and needs no stall.
- RUN length: 10·(CAPACITY+1) cycles.
- Total `busy` cycles: 1 + 10·(CAPACITY+1) + 3.
  - `busy` rises the cycle after `start` is sampled.
  - `done` rises the cycle after `busy` falls.
- DRAIN covers the 2-cycle read latency plus the compare register, so the last E5 read is counted before `done`.

## Structure
- `mbist_pkg` holds:
  - the state enum (IDLE, PRIME, RUN, DRAIN, DONE);
  - the element encoding 0..5;
  - per-element constants: op count, direction, read polarity, write polarity.
- Sub-module `mbist_resp_checker` holds the 2-stage expected/address/element delay pipe, the compare, the saturating counter and the first-fail capture.
- The top level holds the FSM, counters and the memory drive.

## Test plan
- Fault-free memory model, CAPACITY=15, start pulse:
  - `busy` high for exactly 164 cycles;
  - then `done`=1, `pass`=1, `fail_count`=0.
- `fault_mem` with a coupling fault at address 5 → `done` with `pass`=0, `fail_count`≥1, `fail_addr`=5.
- Model with bit 0 of address 3 stuck-at-1:
  - `fail_elem`=1, `fail_addr`=3, `fail_exp`=8'h00, `fail_act`=8'h01;
  - `fail_count`=3 (E1, E3, E5 reads).
- Drive check via bus monitor in E0: `mem_wdata` for the write to address k appears one cycle before `mem_write_read`=1 with `mem_address`=k.
- `start` re-pulsed in cycle 50 → ignored, same 164-cycle run.
- `rst` asserted at cycle 80 → all outputs 0 next cycle, state IDLE; a new `start` gives a full, correct run.
